// File: rtl/inst_cache_slave.sv
// ----------------------------------------------------------------------------
// inst_cache_slave
//
// Direct-mapped instruction cache on the responder side of the fetch port.
// It accepts one PC per cycle. On a hit it returns the instruction one cycle
// later. On a miss it stalls the front end and refills the whole line from
// memory over a burst read port.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   pc_i             fetch address (bits [1:0] ignored for lookup)
//   inst_en_i        fetch request valid
//   flush_i          kills the fetch in flight
//   stall_o          front end must hold pc_i/inst_en_i
//   inst_o           instruction for pc_out_o
//   pc_out_o         address of the returned instruction
//   is_valid_out_o   inst_o/pc_out_o valid this cycle
//   rd_req_o         line read request
//   rd_addr_o        line-aligned read address
//   rd_ready_i       memory accepts rd_req_o
//   ret_valid_i      refill beat valid
//   ret_last_i       final beat of the burst
//   ret_data_i       refill word, word 0 first
// ----------------------------------------------------------------------------
module inst_cache_slave #(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        inst_en_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_out_o,
    output logic        is_valid_out_o,
    output logic        rd_req_o,
    output logic [31:0] rd_addr_o,
    input  logic        rd_ready_i,
    input  logic        ret_valid_i,
    input  logic        ret_last_i,
    input  logic [31:0] ret_data_i
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MISS   = 2'd1,
        S_REFILL = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t             state_q;
    logic [31:0]        req_pc_q;
    logic               req_pend_q;   // a request was accepted last cycle
    logic [OFF_W-1:0]   beat_cnt_q;
    logic               drop_q;
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS][LINE_WORDS];

    logic [IDX_W-1:0]   req_idx;
    logic [OFF_W-1:0]   req_off;
    logic [TAG_W-1:0]   req_tag;
    logic               lookup;
    logic               hit;
    logic               present;
    logic               accept;

    assign req_idx = req_pc_q[TAG_LSB-1:IDX_LSB];
    assign req_off = req_pc_q[IDX_LSB-1:2];
    assign req_tag = req_pc_q[31:TAG_LSB];

    // The lookup happens in the cycle after acceptance, against the latched pc.
    assign lookup  = (state_q == S_IDLE) && req_pend_q;
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign present = (lookup && hit) || (state_q == S_RESP);

    assign stall_o        = (state_q == S_MISS) || (state_q == S_REFILL) ||
                            (lookup && !hit);
    assign is_valid_out_o = present && !flush_i;
    assign inst_o         = is_valid_out_o ? data_q[req_idx][req_off] : 32'h0;
    assign pc_out_o       = req_pc_q;
    assign rd_req_o       = (state_q == S_MISS);
    assign rd_addr_o      = {req_pc_q[31:IDX_LSB], {IDX_LSB{1'b0}}};

    // A new request can be taken whenever the front end is not stalled,
    // including the cycle a hit or refill response is presented.
    assign accept = inst_en_i && !stall_o &&
                    ((state_q == S_IDLE) || (state_q == S_RESP));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            req_pc_q   <= 32'h0;
            req_pend_q <= 1'b0;
            beat_cnt_q <= '0;
            drop_q     <= 1'b0;
            valid_q    <= '0;
        end else begin
            req_pend_q <= accept;
            if (accept) begin
                req_pc_q <= pc_i;
            end
            case (state_q)
                S_IDLE: begin
                    // A flush on the miss-detect cycle kills the request.
                    if (lookup && !hit && !flush_i) begin
                        state_q <= S_MISS;
                    end
                end
                S_MISS: begin
                    // Once memory has accepted, the burst is coming regardless,
                    // so a simultaneous flush only suppresses the response.
                    if (rd_ready_i) begin
                        state_q    <= S_REFILL;
                        beat_cnt_q <= '0;
                        drop_q     <= flush_i;
                    end else if (flush_i) begin
                        state_q <= S_IDLE;
                    end
                end
                S_REFILL: begin
                    if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                    if (ret_valid_i) begin
                        beat_cnt_q <= beat_cnt_q + OFF_W'(1);
                        if (ret_last_i) begin
                            valid_q[req_idx] <= 1'b1;
                            drop_q           <= 1'b0;
                            state_q          <= (drop_q || flush_i) ? S_IDLE : S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == S_REFILL) && ret_valid_i) begin
            data_q[req_idx][beat_cnt_q] <= ret_data_i;
            if (ret_last_i) begin
                tag_q[req_idx] <= req_tag;
            end
        end
    end

endmodule

// File: tb/tb_inst_cache_slave.sv
module tb_inst_cache_slave;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        inst_en_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] inst_o;
    logic [31:0] pc_out_o;
    logic        is_valid_out_o;
    logic        rd_req_o;
    logic [31:0] rd_addr_o;
    logic        rd_ready_i;
    logic        ret_valid_i;
    logic        ret_last_i;
    logic [31:0] ret_data_i;

    int n_vec = 0;
    int n_bad = 0;

    inst_cache_slave #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .pc_i           (pc_i),
        .inst_en_i      (inst_en_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .inst_o         (inst_o),
        .pc_out_o       (pc_out_o),
        .is_valid_out_o (is_valid_out_o),
        .rd_req_o       (rd_req_o),
        .rd_addr_o      (rd_addr_o),
        .rd_ready_i     (rd_ready_i),
        .ret_valid_i    (ret_valid_i),
        .ret_last_i     (ret_last_i),
        .ret_data_i     (ret_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic        en;
        logic        fl;
        logic        exp_v;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
    } vec_t;

    // Reference model: which line tag each set holds, memory as a pure function.
    bit          m_valid [64];
    logic [31:0] m_tag   [64];

    function automatic logic [31:0] memw(input logic [31:0] a);
        logic [31:0] p;
        p = (a & 32'hFFFF_FFFC) * 32'h9E37_79B1;
        return p ^ 32'h0BAD_F00D;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // Full miss transaction starting from a cycle where the cache can accept.
    task automatic fetch_miss(input logic [31:0] pc, input logic [3:0][31:0] w,
                              input int rdly, input int gap, input int flush_beat);
        logic [31:0] line;
        line = pc & 32'hFFFF_FFF0;
        pc_i = pc;
        inst_en_i = 1'b1;
        tick();
        inst_en_i = 1'b0;
        chk("miss_detect_stall", 32'(stall_o), 32'd1);
        chk("miss_detect_valid", 32'(is_valid_out_o), 32'd0);
        tick();
        for (int i = 0; i < rdly; i++) begin
            chk("wait_rd_req", 32'(rd_req_o), 32'd1);
            chk("wait_rd_addr", rd_addr_o, line);
            chk("wait_stall", 32'(stall_o), 32'd1);
            tick();
        end
        chk("rd_req", 32'(rd_req_o), 32'd1);
        chk("rd_addr", rd_addr_o, line);
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        chk("rd_req_drop", 32'(rd_req_o), 32'd0);
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < gap; g++) begin
                chk("refill_gap_stall", 32'(stall_o), 32'd1);
                tick();
            end
            chk("refill_stall", 32'(stall_o), 32'd1);
            ret_valid_i = 1'b1;
            ret_data_i  = w[b];
            ret_last_i  = (b == 3);
            flush_i     = (b == flush_beat);
            tick();
            ret_valid_i = 1'b0;
            ret_last_i  = 1'b0;
            flush_i     = 1'b0;
        end
        chk("resp_stall", 32'(stall_o), 32'd0);
        if (flush_beat < 0) begin
            chk("resp_valid", 32'(is_valid_out_o), 32'd1);
            chk("resp_inst", inst_o, w[pc[3:2]]);
            chk("resp_pc", pc_out_o, pc);
        end else begin
            chk("dropped_valid", 32'(is_valid_out_o), 32'd0);
        end
    endtask

    task automatic do_hit(input logic [31:0] pc, input logic [31:0] exp, input logic fl);
        pc_i = pc;
        inst_en_i = 1'b1;
        tick();
        inst_en_i = 1'b0;
        flush_i = fl;
        #1;
        chk("hit_stall", 32'(stall_o), 32'd0);
        chk("hit_valid", 32'(is_valid_out_o), 32'(!fl));
        if (!fl) begin
            chk("hit_inst", inst_o, exp);
            chk("hit_pc", pc_out_o, pc);
        end
        flush_i = 1'b0;
    endtask

    vec_t tbl [9];

    initial begin
        logic [3:0][31:0] wa, wb, wc, wr;
        rst_i = 1'b0; pc_i = '0; inst_en_i = 1'b0; flush_i = 1'b0;
        rd_ready_i = 1'b0; ret_valid_i = 1'b0; ret_last_i = 1'b0; ret_data_i = '0;
        for (int i = 0; i < 4; i++) begin
            wa[i] = 32'hA0 + 32'(i);
            wb[i] = 32'hB0 + 32'(i);
            wc[i] = 32'hC0 + 32'(i);
        end
        tbl[0] = '{32'h1C00_0000, 1'b1, 1'b0, 1'b1, 32'hA0, 32'h1C00_0000};
        tbl[1] = '{32'h1C00_0004, 1'b1, 1'b0, 1'b1, 32'hA1, 32'h1C00_0004};
        tbl[2] = '{32'h1C00_0008, 1'b1, 1'b0, 1'b1, 32'hA2, 32'h1C00_0008};
        tbl[3] = '{32'h1C00_000C, 1'b1, 1'b0, 1'b1, 32'hA3, 32'h1C00_000C};
        tbl[4] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0};
        tbl[5] = '{32'h1C00_0003, 1'b1, 1'b0, 1'b1, 32'hA0, 32'h1C00_0003};
        tbl[6] = '{32'h1C00_0004, 1'b1, 1'b1, 1'b0, 32'h0,  32'h0};
        tbl[7] = '{32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0,  32'h0};
        tbl[8] = '{32'h1C00_000C, 1'b1, 1'b0, 1'b1, 32'hA3, 32'h1C00_000C};

        do_reset();
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_valid", 32'(is_valid_out_o), 32'd0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc_out", pc_out_o, 32'h0);
        chk("rst_rd_req", 32'(rd_req_o), 32'd0);
        chk("rst_rd_addr", rd_addr_o, 32'h0);

        // Cold miss, then back-to-back hits at full throughput.
        fetch_miss(32'h1C00_0008, wa, 0, 0, -1);
        foreach (tbl[i]) begin
            pc_i = tbl[i].pc;
            inst_en_i = tbl[i].en;
            tick();
            flush_i = tbl[i].fl;
            #1;
            chk("tbl_stall", 32'(stall_o), 32'd0);
            chk("tbl_valid", 32'(is_valid_out_o), 32'(tbl[i].exp_v));
            if (tbl[i].exp_v) begin
                chk("tbl_inst", inst_o, tbl[i].exp_inst);
                chk("tbl_pc", pc_out_o, tbl[i].exp_pc);
            end
            flush_i = 1'b0;
        end
        inst_en_i = 1'b0;
        tick();

        // Conflict eviction and re-miss on the evicted line.
        fetch_miss(32'h1C00_0400, wb, 0, 1, -1);
        fetch_miss(32'h1C00_0004, wa, 0, 0, -1);

        // Flush on the second beat: burst completes, no response, line installed.
        fetch_miss(32'h1C00_0408, wb, 1, 0, 1);
        do_hit(32'h1C00_0408, 32'hB2, 1'b0);

        // rd_ready held off for 5 cycles.
        fetch_miss(32'h2000_001C, wc, 5, 0, -1);
        do_hit(32'h2000_0014, 32'hC1, 1'b0);

        // Reset in the middle of a refill.
        pc_i = 32'h3000_0020;
        inst_en_i = 1'b1;
        tick();
        inst_en_i = 1'b0;
        tick();
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        ret_valid_i = 1'b1;
        ret_data_i = 32'hD0;
        tick();
        ret_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_valid", 32'(is_valid_out_o), 32'd0);
        chk("mid_rst_inst", inst_o, 32'h0);
        chk("mid_rst_pc_out", pc_out_o, 32'h0);
        chk("mid_rst_rd_req", 32'(rd_req_o), 32'd0);
        chk("mid_rst_rd_addr", rd_addr_o, 32'h0);
        pc_i = 32'h3000_0020;
        inst_en_i = 1'b1;
        tick();
        inst_en_i = 1'b0;
        chk("post_rst_miss", 32'(stall_o), 32'd1);
        pc_i = 32'h1C00_0000;
        do_reset();

        // Randomized fetches against the set/tag model.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] pc;
            int idx;
            int r;
            pc = 32'h4000_0000 + 32'($urandom_range(0, 3)) * 32'h400
                 + 32'($urandom_range(0, 3)) * 32'h10
                 + 32'($urandom_range(0, 15));
            idx = int'((pc >> 4) % 64);
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                inst_en_i = 1'b0;
                tick();
                chk("rnd_idle_valid", 32'(is_valid_out_o), 32'd0);
                chk("rnd_idle_stall", 32'(stall_o), 32'd0);
            end else if (m_valid[idx] && m_tag[idx] == (pc >> 10)) begin
                do_hit(pc, memw(pc), logic'(r == 1));
            end else begin
                for (int b = 0; b < 4; b++) wr[b] = memw((pc & 32'hFFFF_FFF0) + 32'(4 * b));
                fetch_miss(pc, wr, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
                           (r == 2) ? int'($urandom_range(0, 3)) : -1);
                m_valid[idx] = 1'b1;
                m_tag[idx]   = pc >> 10;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
